fractal_sync_1d_req_ctrl: RTL

FRACTAL_SYNC_1D_REQ_CTRL -- requirements
Module: fractal_sync_1d_req_ctrl

---
 rtl/fractal_sync_pkg.sv | 42 ++++
 rtl/fractal_sync_1d_req_ctrl_chk.sv | 19 +
 rtl/fractal_sync_req_port.sv | 108 ++++++++++
 rtl/fractal_sync_1d_req_ctrl.sv | 69 ++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
// Shared types for the 1-D fractal-sync request controller.
//   req_state_e : per-port request FSM state (IDLE -> CHECK -> FWD/IDLE)
//   rf_res_e    : classified result of a local RF check
//   rf_decide() : applies the RF result priority (id error > complete >
//                 ignore > none) to the raw RF result bits
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

   typedef enum logic [1:0] {
      REQ_IDLE  = 2'd0,
      REQ_CHECK = 2'd1,
      REQ_FWD   = 2'd2
   } req_state_e;

   typedef enum logic [1:0] {
      RF_NONE = 2'd0,  // first arrival, now stored in the RF
      RF_ERR  = 2'd1,  // id out of range / malformed
      RF_DONE = 2'd2,  // barrier complete (present or bypass)
      RF_DROP = 2'd3   // another port bypasses and forwards this barrier
   } rf_res_e;

   // An id error masks everything else; completion wins over ignore.
   function automatic rf_res_e rf_decide(input logic id_err,
                                         input logic present,
                                         input logic bypass,
                                         input logic ignore);
      rf_res_e res;
      if (id_err) begin
         res = RF_ERR;
      end else if (present || bypass) begin
         res = RF_DONE;
      end else if (ignore) begin
         res = RF_DROP;
      end else begin
         res = RF_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/fractal_sync_1d_req_ctrl_chk.sv
// -----------------------------------------------------------------------------
// fractal_sync_1d_req_ctrl_chk
// Elaboration-time parameter checks for the request controller.
// No ports; instantiated once by the top.
// -----------------------------------------------------------------------------
module fractal_sync_1d_req_ctrl_chk #(
   parameter int unsigned N_PORTS  = 2,
   parameter int unsigned ID_WIDTH = 2
) ();

   if (N_PORTS < 2) begin : g_bad_n_ports
      $error("fractal_sync_1d_req_ctrl: N_PORTS must be >= 2");
   end

   if (ID_WIDTH < 2) begin : g_bad_id_width
      $error("fractal_sync_1d_req_ctrl: ID_WIDTH must be >= 2");
   end

endmodule

// File: rtl/fractal_sync_req_port.sv
// -----------------------------------------------------------------------------
// fractal_sync_req_port
// One request port of the 1-D fractal-sync controller. Accepts a barrier
// request, runs a single-cycle check against the local RF, then either
// forwards the completed barrier upwards, reports an id error, or drops back
// to idle.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i/req_id_i/req_ready_o   request handshake from the child
//   rf_check_o/rf_id_o            check strobe and id to the local RF
//   rf_present_i, rf_id_err_i,
//   rf_bypass_i, rf_ignore_i      RF results, sampled in the check cycle
//   fwd_valid_o/fwd_ready_i/fwd_id_o   completed-barrier forward to parent
//   err_o/err_id_o                one-cycle id-error report (id held)
// -----------------------------------------------------------------------------
module fractal_sync_req_port
   import fractal_sync_pkg::*;
#(
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   input  logic [ID_WIDTH-1:0] req_id_i,
   output logic                req_ready_o,
   output logic                rf_check_o,
   output logic [ID_WIDTH-1:0] rf_id_o,
   input  logic                rf_present_i,
   input  logic                rf_id_err_i,
   input  logic                rf_bypass_i,
   input  logic                rf_ignore_i,
   output logic                fwd_valid_o,
   input  logic                fwd_ready_i,
   output logic [ID_WIDTH-1:0] fwd_id_o,
   output logic                err_o,
   output logic [ID_WIDTH-1:0] err_id_o
);

   req_state_e          state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic                err_q, err_d;
   logic [ID_WIDTH-1:0] err_id_q, err_id_d;

   // Next-state, id latch and error report logic of the request FSM.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      err_d    = 1'b0;
      err_id_d = err_id_q;
      case (state_q)
         REQ_IDLE: begin
            if (req_valid_i) begin
               id_d    = req_id_i;
               state_d = REQ_CHECK;
            end else begin
               state_d = REQ_IDLE;
            end
         end
         REQ_CHECK: begin
            case (rf_decide(rf_id_err_i, rf_present_i, rf_bypass_i, rf_ignore_i))
               RF_ERR: begin
                  err_d    = 1'b1;
                  err_id_d = id_q;
                  state_d  = REQ_IDLE;
               end
               RF_DONE: state_d = REQ_FWD;
               RF_DROP: state_d = REQ_IDLE;
               RF_NONE: state_d = REQ_IDLE;
               default: state_d = REQ_IDLE;
            endcase
         end
         REQ_FWD: begin
            if (fwd_ready_i) begin
               state_d = REQ_IDLE;
            end else begin
               state_d = REQ_FWD;
            end
         end
         default: state_d = REQ_IDLE;
      endcase
   end

   // State, latched id and error report registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= REQ_IDLE;
         id_q     <= {ID_WIDTH{1'b0}};
         err_q    <= 1'b0;
         err_id_q <= {ID_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         err_q    <= err_d;
         err_id_q <= err_id_d;
      end
   end

   // All outputs come straight from registers, so nothing here depends
   // combinationally on the request or RF inputs.
   assign req_ready_o = (state_q == REQ_IDLE);
   assign rf_check_o  = (state_q == REQ_CHECK);
   assign fwd_valid_o = (state_q == REQ_FWD);
   assign rf_id_o     = id_q;
   assign fwd_id_o    = id_q;
   assign err_o       = err_q;
   assign err_id_o    = err_id_q;

endmodule

// File: rtl/fractal_sync_1d_req_ctrl.sv
// -----------------------------------------------------------------------------
// fractal_sync_1d_req_ctrl
// Request controller of one 1-D fractal-sync level: N_PORTS independent
// request ports, each checking its barrier id against the local RF and
// forwarding completed barriers to the parent. Ports never interact here;
// same-cycle collisions are resolved by the RF through bypass/ignore.
// Multi-bit per-port buses are flattened, port p at [p*ID_WIDTH +: ID_WIDTH].
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   req_valid_i, req_id_i, req_ready_o    child requests
//   rf_check_o, rf_id_o                   local RF check strobe / id
//   rf_present_i, rf_id_err_i,
//   rf_bypass_i, rf_ignore_i              local RF results
//   fwd_valid_o, fwd_ready_i, fwd_id_o    forward to parent level
//   err_o, err_id_o                       id-error report
// -----------------------------------------------------------------------------
module fractal_sync_1d_req_ctrl
   import fractal_sync_pkg::*;
#(
   parameter int unsigned N_PORTS  = 2,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [N_PORTS-1:0]           req_valid_i,
   input  logic [N_PORTS*ID_WIDTH-1:0]  req_id_i,
   output logic [N_PORTS-1:0]           req_ready_o,
   output logic [N_PORTS-1:0]           rf_check_o,
   output logic [N_PORTS*ID_WIDTH-1:0]  rf_id_o,
   input  logic [N_PORTS-1:0]           rf_present_i,
   input  logic [N_PORTS-1:0]           rf_id_err_i,
   input  logic [N_PORTS-1:0]           rf_bypass_i,
   input  logic [N_PORTS-1:0]           rf_ignore_i,
   output logic [N_PORTS-1:0]           fwd_valid_o,
   input  logic [N_PORTS-1:0]           fwd_ready_i,
   output logic [N_PORTS*ID_WIDTH-1:0]  fwd_id_o,
   output logic [N_PORTS-1:0]           err_o,
   output logic [N_PORTS*ID_WIDTH-1:0]  err_id_o
);

   fractal_sync_1d_req_ctrl_chk #(
      .N_PORTS  (N_PORTS),
      .ID_WIDTH (ID_WIDTH)
   ) u_chk ();

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      fractal_sync_req_port #(
         .ID_WIDTH (ID_WIDTH)
      ) u_port (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .req_valid_i  (req_valid_i[p]),
         .req_id_i     (req_id_i[p*ID_WIDTH +: ID_WIDTH]),
         .req_ready_o  (req_ready_o[p]),
         .rf_check_o   (rf_check_o[p]),
         .rf_id_o      (rf_id_o[p*ID_WIDTH +: ID_WIDTH]),
         .rf_present_i (rf_present_i[p]),
         .rf_id_err_i  (rf_id_err_i[p]),
         .rf_bypass_i  (rf_bypass_i[p]),
         .rf_ignore_i  (rf_ignore_i[p]),
         .fwd_valid_o  (fwd_valid_o[p]),
         .fwd_ready_i  (fwd_ready_i[p]),
         .fwd_id_o     (fwd_id_o[p*ID_WIDTH +: ID_WIDTH]),
         .err_o        (err_o[p]),
         .err_id_o     (err_id_o[p*ID_WIDTH +: ID_WIDTH])
      );
   end

endmodule
